// File: rtl/rat_pc_pkg.sv
// Shared types and constants for the RAT MCU program counter / fetch sequencer.
package rat_pc_pkg;

    localparam int                PC_WIDTH    = 10;
    localparam logic [PC_WIDTH-1:0] INTR_VECTOR = 10'h3FF;

    typedef enum logic [1:0] {
        FROM_IMMED = 2'd0,
        FROM_STACK = 2'd1,
        FROM_INTR  = 2'd2,
        SEL_RSVD   = 2'd3
    } pc_sel_t;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC selection: load mux has priority over increment; increment wraps modulo 2^PC_WIDTH.
module pc_next_mux
    import rat_pc_pkg::pc_sel_t;
    import rat_pc_pkg::FROM_IMMED;
    import rat_pc_pkg::FROM_STACK;
    import rat_pc_pkg::FROM_INTR;
#(
    parameter int                   PC_W     = 10,
    parameter logic [PC_W-1:0]      INTR_VEC = '1
) (
    input  logic [PC_W-1:0] pc,
    input  pc_sel_t         sel,
    input  logic            ld,
    input  logic            inc,
    input  logic [PC_W-1:0] immed,
    input  logic [PC_W-1:0] stack,
    output logic [PC_W-1:0] pc_nxt,
    output logic            wrap
);

    always_comb begin
        pc_nxt = pc;
        wrap   = 1'b0;
        if (ld) begin
            // The reserved select holds the PC silently.
            case (sel)
                FROM_IMMED: pc_nxt = immed;
                FROM_STACK: pc_nxt = stack;
                FROM_INTR:  pc_nxt = INTR_VEC;
                default:    pc_nxt = pc;
            endcase
        end else if (inc) begin
            {wrap, pc_nxt} = {1'b0, pc} + (PC_W + 1)'(1);
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and fetch sequencer for the RAT MCU; tracks the address of the instruction leaving the 1-cycle ROM.
// Optional breakpoint/HALT support is enabled by defining PC_BREAKPOINT_EN.
module pc_fetch_unit #(
    parameter int                       PC_WIDTH    = rat_pc_pkg::PC_WIDTH,
    parameter logic [PC_WIDTH-1:0]      RESET_ADDR  = '0,
    parameter logic [PC_WIDTH-1:0]      INTR_VECTOR = rat_pc_pkg::INTR_VECTOR
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                PC_LD,
    input  logic                PC_INC,
    input  logic [1:0]          PC_MUX_SEL,
    input  logic [PC_WIDTH-1:0] FROM_IMMED,
    input  logic [PC_WIDTH-1:0] FROM_STACK,
    input  logic                STALL,
    output logic [PC_WIDTH-1:0] PC_COUNT,
    output logic [PC_WIDTH-1:0] IR_ADDR,
    output logic                IR_VALID,
    output logic                PC_WRAP,
    input  logic [PC_WIDTH-1:0] BRK_ADDR,
    input  logic                BRK_EN,
    input  logic                RESUME,
    output logic                BRK_HIT
);

    import rat_pc_pkg::*;

    fetch_state_t        state, state_nxt;
    logic [PC_WIDTH-1:0] pc_nxt;
    logic                inc_wrap;
    logic                trap;
    logic                pc_upd, ir_upd, valid_set, brk_set, brk_clr;

    pc_next_mux #(
        .PC_W     (PC_WIDTH),
        .INTR_VEC (INTR_VECTOR)
    ) u_next (
        .pc     (PC_COUNT),
        .sel    (pc_sel_t'(PC_MUX_SEL)),
        .ld     (PC_LD),
        .inc    (PC_INC),
        .immed  (FROM_IMMED),
        .stack  (FROM_STACK),
        .pc_nxt (pc_nxt),
        .wrap   (inc_wrap)
    );

`ifdef PC_BREAKPOINT_EN
    logic resume_sup;
    // The first RUN cycle after RESUME skips the compare so the halted address does not re-trap.
    assign trap    = BRK_EN && (PC_COUNT == BRK_ADDR) && !STALL && !resume_sup;
    assign brk_clr = (state == HALT) && RESUME;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            resume_sup <= 1'b0;
            BRK_HIT    <= 1'b0;
        end else begin
            resume_sup <= brk_clr;
            if (brk_set)
                BRK_HIT <= 1'b1;
            else if (brk_clr)
                BRK_HIT <= 1'b0;
        end
    end
`else
    logic unused_brk;
    assign unused_brk = ^{BRK_ADDR, BRK_EN, RESUME};
    assign trap       = 1'b0;
    assign brk_clr    = 1'b0;
    assign BRK_HIT    = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            state <= BOOT;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            BOOT:    state_nxt = RUN;
            RUN:     state_nxt = trap ? HALT : RUN;
            HALT:    state_nxt = brk_clr ? RUN : HALT;
            default: state_nxt = BOOT;
        endcase
    end

    always_comb begin
        pc_upd    = (state == RUN) && !STALL && !trap;
        ir_upd    = (state == RUN) && !STALL;
        valid_set = (state == BOOT);
        brk_set   = (state == RUN) && trap;
    end

    // IR_ADDR trails PC_COUNT by one cycle to match the ROM read latency.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            PC_COUNT <= RESET_ADDR;
            IR_ADDR  <= RESET_ADDR;
            IR_VALID <= 1'b0;
            PC_WRAP  <= 1'b0;
        end else begin
            if (pc_upd)
                PC_COUNT <= pc_nxt;
            if (pc_upd && inc_wrap)
                PC_WRAP <= 1'b1;
            if (ir_upd)
                IR_ADDR <= PC_COUNT;
            if (valid_set)
                IR_VALID <= 1'b1;
        end
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program counter and fetch sequencer for the RAT MCU on Basys3.
- Drives the 10-bit fetch address into the 1024x18 synchronous program ROM, which has one cycle of read latency.
- Tracks which address the instruction currently leaving the ROM came from, and flags whether that instruction is valid.
- Sits between the control unit (load/increment/select strobes) and the program ROM.

Parameters:
- PC_WIDTH, 10, address width; matches 1024-entry ROM.
- RESET_ADDR, 10'h000, PC value after reset.
- INTR_VECTOR, 10'h3FF, interrupt service address selected by PC_MUX_SEL=2.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- PC_LD  in  1  load PC from mux selection.
- PC_INC  in  1  increment PC.
- PC_MUX_SEL  in  2  0=FROM_IMMED, 1=FROM_STACK, 2=INTR_VECTOR, 3=reserved.
- FROM_IMMED  in  10  branch/call target from IR.
- FROM_STACK  in  10  return address from scratch RAM.
- STALL  in  1  freeze PC and fetch tracking.
- PC_COUNT  out  10  current PC; drives ROM PROG_ADDR.
- IR_ADDR  out  10  address of the instruction currently on ROM PROG_IR.
- IR_VALID  out  1  PROG_IR holds a real fetched instruction.
- PC_WRAP  out  1  sticky; set on increment from 0x3FF to 0x000.
- BRK_ADDR  in  10  breakpoint address (optional feature).
- BRK_EN  in  1  breakpoint arm (optional feature).
- RESUME  in  1  leave HALT (optional feature).
- BRK_HIT  out  1  halted on breakpoint (optional feature).

Behaviour:
- Reset (async, RST=1):
  - PC_COUNT=RESET_ADDR, IR_ADDR=RESET_ADDR, IR_VALID=0, PC_WRAP=0, BRK_HIT=0.
  - FSM enters BOOT.
  - Deasserting RST mid-operation restarts cleanly from BOOT.
- FSM states: BOOT, RUN, HALT.
  - BOOT: lasts exactly one cycle. PC held. Next state RUN. IR_VALID goes to 1 at the end of the BOOT cycle, because ROM output is now valid for RESET_ADDR.
  - RUN: normal operation.
  - HALT: only reachable with the optional feature.
- PC update in RUN, evaluated each rising edge, in priority order:
  - STALL=1: PC, IR_ADDR and IR_VALID all hold.
  - else PC_LD=1: PC <= mux(PC_MUX_SEL). PC_INC is ignored when PC_LD is also 1.
  - else PC_INC=1: PC <= PC+1, modulo 1024.
  - else: PC holds.
- PC_MUX_SEL=3 with PC_LD=1: PC holds; no error is raised.
- Fetch tracking (unstalled RUN cycle): IR_ADDR <= PC_COUNT, so IR_ADDR is always PC_COUNT delayed one cycle, matching ROM latency.
- IR_VALID:
  - Remains 1 through RUN, including across loads. Target data appears one cycle after PC_LD because the ROM reads the current PC.
  - Drops to 0 only on reset.
- Wrap-around: increment at PC=0x3FF gives 0x000 and sets PC_WRAP. PC_WRAP clears only on RST.
- Loads never set PC_WRAP.
- All outputs are registered; nothing is combinational from inputs.

Optional Feature:
- Macro: PC_BREAKPOINT_EN.
- Defined:
  - In RUN, if BRK_EN=1 and PC_COUNT==BRK_ADDR and STALL=0, the next state is HALT and BRK_HIT=1.
  - In HALT, PC, IR_ADDR and IR_VALID are frozen and PC_LD/PC_INC are ignored.
  - RESUME=1 returns to RUN and clears BRK_HIT. During the first RUN cycle after RESUME, the breakpoint compare is suppressed, so the same address does not re-trap immediately.
  - STALL has priority over the breakpoint check.
- Undefined:
  - BRK_ADDR, BRK_EN and RESUME are ignored; BRK_HIT is tied to 0.
  - HALT is unreachable.

Decomposition:
- Package rat_pc_pkg contains:
  - PC_WIDTH.
  - INTR_VECTOR.
  - Enum pc_sel_t {FROM_IMMED, FROM_STACK, FROM_INTR, SEL_RSVD}.
  - Enum fetch_state_t {BOOT, RUN, HALT}.
- One sub-module, pc_next_mux: combinational next-PC selection and increment-with-wrap. The FSM and registers stay in the top level.

Test Plan:
- RST pulse, then 3 cycles of PC_INC=1:
  - BOOT cycle: PC_COUNT=0, IR_VALID=0.
  - Then PC_COUNT 1,2,3; IR_ADDR 0,1,2; IR_VALID=1.
- PC_LD=1, PC_MUX_SEL=0, FROM_IMMED=0x155, PC_INC=1 in the same cycle: PC_COUNT=0x155 (not old PC+1); next cycle IR_ADDR=0x155.
- PC_LD with SEL=2, then SEL=1 with FROM_STACK=0x042: PC_COUNT=0x3FF, then 0x042. SEL=3: PC unchanged.
- Load 0x3FE, then PC_INC x2: PC_COUNT 0x3FF then 0x000; PC_WRAP=1 and stays 1 until RST.
- STALL=1 for 4 cycles with PC_INC=1 at PC=0x010: PC_COUNT=0x010 and IR_ADDR constant; resumes at 0x011 when STALL drops.
- PC_BREAKPOINT_EN defined, BRK_ADDR=0x005, BRK_EN=1, free-running PC_INC:
  - Halts with PC_COUNT=0x005, BRK_HIT=1, PC frozen for 10 cycles.
  - RESUME pulse gives PC 0x006 with no re-trap.
  - RST asserted mid-HALT returns to BOOT with BRK_HIT=0.
